spart_bus_ctrl: RTL and testbench
=================================

# spart_bus_ctrl

Bus controller and 2-client arbiter for the SPART register interface. After reset, and whenever `br_cfg` changes, it programs the baud divisor registers. It then shares the SPART transmit/receive buffer between two requesters, issuing single-cycle bus transactions gated on `rda`/`tbr`. It sits between the processor-side clients and the SPART `iocs/iorw/ioaddr/databus` port and replaces ad-hoc driver sequencing.

## Interface
- `CFG_SETTLE`, default 4: cycles `br_cfg` must be stable at a new value before reprogramming starts.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `br_cfg` in 2: baud select. 00=4800, 01=9600, 10=19200, 11=38400.
- `iocs` out 1: SPART chip select. One-cycle pulse per bus transaction.
- `iorw` out 1: 1=read, 0=write.
- `ioaddr` out 2: 00=TX/RX buffer, 01=status, 10=DB low, 11=DB high.
- `databus` inout 8: driven only when `iocs & ~iorw`, otherwise high-Z.
- `rda` in 1: SPART receive data available.
- `tbr` in 1: SPART transmit buffer ready.
- `req` in 2: per-client request. Held until that client's `done`.
- `wr` in 2: per-client direction. 1=write, 0=read. Stable while `req` is held.
- `wdata0`, `wdata1` in 8: client write data. Stable while `req` is held.
- `done` out 2: one-cycle completion pulse per client.
- `rdata` out 8: read data. Valid in the `done` cycle and held until the next read.
- `ready` out 1: divisor programmed, arbitration active.

## Operation
- Divisor table, 100 MHz, ÷16 oversample, {DBH,DBL}: 4800=0x0516, 9600=0x028B, 19200=0x0146, 38400=0x00A3.
- States: CFG_LO, CFG_HI, IDLE, XFER, HOLD.
- CFG_LO: write DBL at `ioaddr`=10. Then CFG_HI: write DBH at `ioaddr`=11. Then IDLE with `ready`=1.
- IDLE: client i is eligible if `req[i] & (wr[i] ? tbr : rda)` and `done[i]` is not pulsing this cycle.
  - If any client is eligible, latch the winner, go to XFER.
  - If none is eligible, stay in IDLE.
- Arbitration: round-robin. After reset client 0 has priority. After a grant, the other client has priority.
- XFER, write: `iocs`=1, `iorw`=0, `ioaddr`=00, `databus`=winner's wdata.
- XFER, read: `iocs`=1, `iorw`=1, `ioaddr`=00, `databus` sampled into `rdata` at the clock edge.
- HOLD: `done[winner]`=1, `iocs`=0. Gives the SPART one cycle to update `rda`/`tbr`. Then IDLE.
- Reconfiguration:
  - `br_cfg_q` is registered. A differing `br_cfg` that stays stable for `CFG_SETTLE` consecutive cycles sets `cfg_pend`.
  - `cfg_pend` is serviced from IDLE only, so an in-flight XFER/HOLD completes first. It has priority over new grants.
  - On service: `ready` goes 0 and the state goes to CFG_LO. `cfg_pend` is cleared on entering CFG_LO.
  - If `br_cfg` changes again before settling, the settle counter restarts.
- Clients with no eligibility wait indefinitely. There is no timeout.

## Timing
- Reset values: `iocs`=0, `iorw`=1, `ioaddr`=00, `databus`=Z, `done`=00, `rdata`=0x00, `ready`=0. State=CFG_LO, RR priority=client 0.
- After `rst` falls: CFG_LO in cycle 0, CFG_HI in cycle 1, `ready`=1 from cycle 2.
- Transaction latency: an eligible request in IDLE cycle t gives XFER at t+1, `done` at t+2, earliest next grant at t+3.
- The client must drop `req`, or change it for a new transaction, in the cycle after `done`. `req` is masked during `done`, so the same transaction is never issued twice.
- Simultaneous eligible requests: only the RR winner is granted. The loser is granted in the next IDLE if it is still eligible.
- `rst` asserted mid-transaction:
  - Outputs go to reset values immediately. `databus` releases asynchronously.
  - The pending transaction is dropped with no `done`. Full reconfiguration follows.
- `rda`/`tbr` are sampled in IDLE only. Deassertion during XFER does not abort the transaction.

## Structure
- Package `spart_pkg`:
  - `ioaddr` constants (ADDR_BUF, ADDR_STAT, ADDR_DBL, ADDR_DBH).
  - Divisor table as a function of `br_cfg`, returning 16 bits.
  - State enum.
- Sub-module `spart_rr_arb`: 2-way round-robin arbiter. Inputs: eligible[1:0], advance. Outputs: one-hot grant[1:0]. Priority register reset to client 0.
- Top level holds the FSM, settle counter, tri-state driver and `rdata` register.

## Test plan
- Reset release with `br_cfg`=01 → write 0x8B @10, then 0x02 @11, on consecutive cycles. `ready`=1 at cycle 2.
- Client 0 write 0x41 with `tbr`=1 → one `iocs` pulse with `iorw`=0, `ioaddr`=00, `databus`=0x41. `done`=01 the next cycle.
- Both clients read with `rda`=1, SPART returning 0x5A then 0xA5 → client 0 gets 0x5A, then client 1 gets 0xA5. Grants are 3 cycles apart.
- `br_cfg` 01→11 during a client 1 write → write completes with `done`=10, then `ready`=0, then 0xA3 @10 and 0x00 @11 are written. A `br_cfg` glitch shorter than 4 cycles causes no reprogramming.
- `req`=01 read with `rda`=0 for 50 cycles → no `iocs` activity. `rda`=1 → transaction within 2 cycles.
- `rst` pulsed during XFER → `iocs`=0 and `databus`=Z immediately, no `done`, reconfiguration restarts.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared constants, state encoding and baud divisor table for the SPART bus controller.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    XFER,
    HOLD
  } state_e;

  // {DBH,DBL} for a 100 MHz clock with 16x oversampling
  function automatic logic [15:0] divisor(input logic [1:0] br_cfg);
    logic [15:0] div;
    case (br_cfg)
      2'b00:   div = 16'h0516;
      2'b01:   div = 16'h028B;
      2'b10:   div = 16'h0146;
      default: div = 16'h00A3;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/spart_rr_arb.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority flips to the
// other client whenever a grant is taken.
module spart_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eligible,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio_q, prio_d;

  always_comb begin
    grant = 2'b00;
    if (!prio_q) begin
      grant[0] = eligible[0];
      grant[1] = eligible[1] & ~eligible[0];
    end else begin
      grant[1] = eligible[1];
      grant[0] = eligible[0] & ~eligible[1];
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (advance && (grant != 2'b00)) prio_d = grant[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/spart_bus_ctrl.sv
// SPART bus controller: programs the baud divisor after reset or a settled br_cfg
// change, then arbitrates single-cycle buffer transactions between two clients.
module spart_bus_ctrl
  import spart_pkg::*;
#(
  parameter int unsigned CFG_SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr,
  input  logic [1:0] req,
  input  logic [1:0] wr,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] done,
  output logic [7:0] rdata,
  output logic       ready
);

  localparam int unsigned CNT_W = $clog2(CFG_SETTLE + 1);

  state_e            state_q, state_d;
  logic              iocs_q, iocs_d, iorw_q, iorw_d, ready_q, ready_d;
  logic [1:0]        ioaddr_q, ioaddr_d, done_q, done_d;
  logic [7:0]        wdata_q, wdata_d, rdata_q, rdata_d;
  logic              win_q, win_d;
  logic [1:0]        br_cfg_q, br_cfg_d, cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nx;
  logic              pend_q, pend_d;
  logic [1:0]        elig_c, grant;
  logic              advance;
  logic [1:0]        cfg_sel;
  logic [15:0]       div;

  always_comb begin
    elig_c[0] = req[0] & ~done_q[0] & (wr[0] ? tbr : rda);
    elig_c[1] = req[1] & ~done_q[1] & (wr[1] ? tbr : rda);
  end

  assign advance = (state_q == IDLE) && !pend_q && (elig_c != 2'b00);

  spart_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .eligible (elig_c),
    .advance  (advance),
    .grant    (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CFG_LO;
    else     state_q <= state_d;
  end

  // CFG_LO lingers one cycle out of reset so the DBL write is registered like every other
  always_comb begin
    state_d = state_q;
    case (state_q)
      CFG_LO:  if (iocs_q) state_d = CFG_HI;
      CFG_HI:  state_d = IDLE;
      IDLE: begin
        if (pend_q)                 state_d = CFG_LO;
        else if (elig_c != 2'b00)   state_d = XFER;
      end
      XFER:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = CFG_LO;
    endcase
  end

  assign cfg_sel = (state_d == CFG_LO) ? br_cfg : br_cfg_q;
  assign div     = divisor(cfg_sel);

  // Registered outputs decode the state being entered so they line up with state_q
  always_comb begin
    iocs_d   = 1'b0;
    iorw_d   = 1'b1;
    ioaddr_d = ADDR_BUF;
    wdata_d  = wdata_q;
    done_d   = 2'b00;
    ready_d  = 1'b0;
    win_d    = win_q;
    case (state_d)
      CFG_LO: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DBL;
        wdata_d  = div[7:0];
      end
      CFG_HI: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DBH;
        wdata_d  = div[15:8];
      end
      IDLE: ready_d = 1'b1;
      XFER: begin
        ready_d = 1'b1;
        iocs_d  = 1'b1;
        win_d   = (grant == 2'b10);
        iorw_d  = win_d ? ~wr[1] : ~wr[0];
        wdata_d = win_d ? wdata1 : wdata0;
      end
      HOLD: begin
        ready_d = 1'b1;
        done_d  = win_q ? 2'b10 : 2'b01;
      end
      default: ready_d = 1'b0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if ((state_q == XFER) && iorw_q) rdata_d = databus;
  end

  // Settle tracker: a new br_cfg must be seen CFG_SETTLE consecutive edges before it is pended
  always_comb begin
    br_cfg_d = br_cfg_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    cnt_nx   = ((br_cfg == cand_q) && (cnt_q != '0)) ? cnt_q + CNT_W'(1) : CNT_W'(1);
    if (state_d == CFG_LO) begin
      br_cfg_d = br_cfg;
      cand_d   = br_cfg;
      cnt_d    = '0;
      pend_d   = 1'b0;
    end else if (!pend_q) begin
      if (br_cfg == br_cfg_q) begin
        cnt_d = '0;
      end else begin
        cand_d = br_cfg;
        if (cnt_nx >= CNT_W'(CFG_SETTLE)) begin
          pend_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d  = cnt_nx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iocs_q   <= 1'b0;
      iorw_q   <= 1'b1;
      ioaddr_q <= ADDR_BUF;
      wdata_q  <= 8'h00;
      done_q   <= 2'b00;
      rdata_q  <= 8'h00;
      ready_q  <= 1'b0;
      win_q    <= 1'b0;
      br_cfg_q <= 2'b00;
      cand_q   <= 2'b00;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      iocs_q   <= iocs_d;
      iorw_q   <= iorw_d;
      ioaddr_q <= ioaddr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      win_q    <= win_d;
      br_cfg_q <= br_cfg_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
    end
  end

  assign databus = (iocs_q && !iorw_q) ? wdata_q : 8'hzz;
  assign iocs    = iocs_q;
  assign iorw    = iorw_q;
  assign ioaddr  = ioaddr_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Directed-plus-random bench for spart_bus_ctrl with a small SPART bus model and
// a behavioural round-robin / divisor-table reference.
module tb_spart_bus_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] br_cfg;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda, tbr;
  logic [1:0] req, wr;
  logic [7:0] wdata0, wdata1;
  logic [1:0] done;
  logic [7:0] rdata;
  logic       ready;

  logic [7:0] spart_rx;
  int         total, bad;
  int         rr_prio;
  logic [7:0] last_rd;
  logic [1:0] cur_cfg;
  logic [15:0] div_tab [4];

  spart_bus_ctrl #(.CFG_SETTLE(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .br_cfg  (br_cfg),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr),
    .req     (req),
    .wr      (wr),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .done    (done),
    .rdata   (rdata),
    .ready   (ready)
  );

  // SPART side: returns spart_rx whenever the controller reads
  assign databus = (iocs && iorw) ? spart_rx : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int c);
    return (c == 0) ? 2'b01 : 2'b10;
  endfunction

  // Waits (bounded) for the DBL write, then expects DBH and ready on the following cycles
  task automatic expect_cfg(input logic [1:0] cfg, input int max_wait, output int waited);
    logic [15:0] dv;
    dv = div_tab[cfg];
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!iocs && waited < max_wait);
    check("cfg_lo_iocs",  16'(iocs), 16'd1);
    check("cfg_lo_ready", 16'(ready), 16'd0);
    check("cfg_lo_iorw",  16'(iorw), 16'd0);
    check("cfg_lo_addr",  16'(ioaddr), 16'd2);
    check("cfg_lo_data",  16'(databus), 16'(dv[7:0]));
    @(negedge clk);
    check("cfg_hi_iocs",  16'(iocs), 16'd1);
    check("cfg_hi_addr",  16'(ioaddr), 16'd3);
    check("cfg_hi_data",  16'(databus), 16'(dv[15:8]));
    @(negedge clk);
    check("cfg_end_iocs",  16'(iocs), 16'd0);
    check("cfg_end_ready", 16'(ready), 16'd1);
  endtask

  task automatic xfer_checks(input string tag, input bit is_wr, input logic [7:0] d);
    check({tag, "_iocs"}, 16'(iocs), 16'd1);
    check({tag, "_iorw"}, 16'(iorw), 16'(!is_wr));
    check({tag, "_addr"}, 16'(ioaddr), 16'd0);
    if (is_wr) check({tag, "_data"}, 16'(databus), 16'(d));
  endtask

  task automatic single(input int c, input bit is_wr, input logic [7:0] d, input logic [7:0] rx);
    @(posedge clk); #1;
    req[c] = 1'b1;
    wr[c]  = is_wr;
    if (c == 0) wdata0 = d; else wdata1 = d;
    spart_rx = rx;
    tbr = is_wr;
    rda = !is_wr;
    @(negedge clk);
    check("single_pre_iocs", 16'(iocs), 16'd0);
    @(negedge clk);
    xfer_checks("single", is_wr, d);
    check("single_xfer_done", 16'(done), 16'd0);
    @(negedge clk);
    if (!is_wr) last_rd = rx;
    check("single_done", 16'(done), 16'(onehot(c)));
    check("single_hold_iocs", 16'(iocs), 16'd0);
    check("single_rdata", 16'(rdata), 16'(last_rd));
    @(posedge clk); #1;
    req[c] = 1'b0;
    rr_prio = 1 - c;
  endtask

  // Both clients eligible at once: RR winner first, loser three cycles later
  task automatic dual(input logic [1:0] wv, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] ra, input logic [7:0] rb);
    int f, s;
    f = rr_prio;
    s = 1 - f;
    @(posedge clk); #1;
    req = 2'b11; wr = wv; wdata0 = d0; wdata1 = d1;
    tbr = 1'b1; rda = 1'b1; spart_rx = ra;
    @(negedge clk);
    check("dual_pre_iocs", 16'(iocs), 16'd0);
    @(negedge clk);
    xfer_checks("dual_first", wv[f], (f == 0) ? d0 : d1);
    @(negedge clk);
    if (!wv[f]) last_rd = ra;
    check("dual_first_done", 16'(done), 16'(onehot(f)));
    check("dual_first_rdata", 16'(rdata), 16'(last_rd));
    @(posedge clk); #1;
    req[f] = 1'b0;
    spart_rx = rb;
    @(negedge clk);
    check("dual_gap_iocs", 16'(iocs), 16'd0);
    check("dual_gap_done", 16'(done), 16'd0);
    @(negedge clk);
    xfer_checks("dual_second", wv[s], (s == 0) ? d0 : d1);
    @(negedge clk);
    if (!wv[s]) last_rd = rb;
    check("dual_second_done", 16'(done), 16'(onehot(s)));
    check("dual_second_rdata", 16'(rdata), 16'(last_rd));
    @(posedge clk); #1;
    req = 2'b00;
    rr_prio = f;
  endtask

  initial begin
    int w, cnt;
    logic [7:0] d;
    logic [1:0] nc;
    total = 0; bad = 0; rr_prio = 0; last_rd = 8'h00;
    div_tab = '{16'h0516, 16'h028B, 16'h0146, 16'h00A3};
    rst = 1'b1; br_cfg = 2'b01; cur_cfg = 2'b01;
    req = 2'b00; wr = 2'b00; wdata0 = 8'h00; wdata1 = 8'h00;
    rda = 1'b0; tbr = 1'b0; spart_rx = 8'h00;

    // Reset values and first programming sequence
    repeat (3) @(negedge clk);
    check("rst_iocs",   16'(iocs), 16'd0);
    check("rst_iorw",   16'(iorw), 16'd1);
    check("rst_addr",   16'(ioaddr), 16'd0);
    check("rst_done",   16'(done), 16'd0);
    check("rst_rdata",  16'(rdata), 16'd0);
    check("rst_ready",  16'(ready), 16'd0);
    rst = 1'b0;
    expect_cfg(cur_cfg, 1, w);
    check("rst_cfg_latency", 16'(w), 16'd1);

    // Directed single transactions, then both clients reading
    single(0, 1'b1, 8'h41, 8'h00);
    single(1, 1'b0, 8'h00, 8'($urandom));
    dual(2'b00, 8'h00, 8'h00, 8'h5A, 8'hA5);
    for (int k = 0; k < 4; k++)
      dual(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

    // br_cfg change during a client 1 write
    d = 8'($urandom);
    @(posedge clk); #1;
    req[1] = 1'b1; wr[1] = 1'b1; wdata1 = d; tbr = 1'b1; br_cfg = 2'b11; cur_cfg = 2'b11;
    @(negedge clk);
    @(negedge clk);
    xfer_checks("recfg_xfer", 1'b1, d);
    @(negedge clk);
    check("recfg_done", 16'(done), 16'b10);
    @(posedge clk); #1;
    req[1] = 1'b0;
    expect_cfg(cur_cfg, 12, w);

    // Glitch shorter than the settle window must not reprogram
    @(posedge clk); #1;
    br_cfg = 2'b01;
    repeat (3) @(posedge clk);
    #1 br_cfg = 2'b11;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (iocs) cnt++;
    end
    check("glitch_no_iocs", 16'(cnt), 16'd0);
    check("glitch_ready", 16'(ready), 16'd1);

    // Random settled reconfiguration
    nc = cur_cfg ^ 2'($urandom_range(1, 3));
    @(posedge clk); #1;
    br_cfg = nc; cur_cfg = nc;
    expect_cfg(cur_cfg, 12, w);

    // Read with rda low waits indefinitely, then completes promptly
    @(posedge clk); #1;
    req[0] = 1'b1; wr[0] = 1'b0; rda = 1'b0; tbr = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (iocs) cnt++;
    end
    check("starve_no_iocs", 16'(cnt), 16'd0);
    d = 8'($urandom);
    @(posedge clk); #1;
    rda = 1'b1; spart_rx = d;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!iocs && w < 2);
    xfer_checks("starve_xfer", 1'b0, 8'h00);
    @(negedge clk);
    last_rd = d;
    check("starve_done", 16'(done), 16'b01);
    check("starve_rdata", 16'(rdata), 16'(d));
    @(posedge clk); #1;
    req[0] = 1'b0;
    rr_prio = 1;

    // Reset asserted mid-transaction
    d = 8'($urandom);
    @(posedge clk); #1;
    req[0] = 1'b1; wr[0] = 1'b1; wdata0 = d; tbr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    xfer_checks("rstmid_xfer", 1'b1, d);
    #1 rst = 1'b1;
    #1;
    check("rstmid_iocs",  16'(iocs), 16'd0);
    check("rstmid_iorw",  16'(iorw), 16'd1);
    check("rstmid_ready", 16'(ready), 16'd0);
    check("rstmid_rdata", 16'(rdata), 16'd0);
    req = 2'b00;
    last_rd = 8'h00;
    rr_prio = 0;
    repeat (3) begin
      @(negedge clk);
      check("rstmid_no_done", 16'(done), 16'd0);
    end
    rst = 1'b0;
    expect_cfg(cur_cfg, 1, w);
    check("rstmid_cfg_latency", 16'(w), 16'd1);
    single(0, 1'b0, 8'h00, 8'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
